// File: rtl/map_write_arbiter.sv
`default_nettype none
//============================================================================
// Module      : map_write_arbiter
// Description : Owns the single write port of the game-map tile RAM and
//               shares it between three movers (pacman, ghost1, ghost2).
//               Each granted move runs a fixed sequence: read the target
//               tile, erase the old cell, write the sprite at the new cell,
//               then pulse done to the requester.
// Build option: PILL_COUNT_EN - when defined, a saturating 16-bit counter
//               of pills eaten by pacman is built; otherwise pills_eaten_o
//               is tied to zero. Sequence timing is identical either way.
// Ports       :
//   CLOCK_50        in   system clock
//   reset           in   synchronous, active-high
//   req_i           in   [2:0]  level requests {g2,g1,pac}, held until done
//   curr_x_all_i    in   [17:0] {g2,g1,pac} current x, 6b each
//   curr_y_all_i    in   [14:0] {g2,g1,pac} current y, 5b each
//   next_x_all_i    in   [17:0] {g2,g1,pac} next x
//   next_y_all_i    in   [14:0] {g2,g1,pac} next y
//   ram_rdata_i     in   [TILE_W-1:0] map RAM read data (1-cycle latency)
//   ram_addr_o      out  [10:0] RAM address {y,x}
//   ram_wdata_o     out  [TILE_W-1:0] RAM write data
//   ram_we_o        out  RAM write enable (ERASE and WRITE only)
//   grant_o         out  [2:0] one-hot requester being served
//   done_o          out  [2:0] one-cycle "move committed" pulse
//   busy_o          out  high whenever not idle
//   pills_eaten_o   out  [15:0] pills eaten by pacman (optional)
// Revision    : 1.0 - initial release
//============================================================================
module map_write_arbiter #(
    parameter int                TILE_W      = 4,
    parameter logic [TILE_W-1:0] EMPTY_CODE  = 4'd0,
    parameter logic [TILE_W-1:0] PILL_CODE   = 4'd2,
    parameter logic [TILE_W-1:0] PACMAN_CODE = 4'd3,
    parameter logic [TILE_W-1:0] GHOST_CODE  = 4'd4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [2:0]        req_i,
    input  logic [17:0]       curr_x_all_i,
    input  logic [14:0]       curr_y_all_i,
    input  logic [17:0]       next_x_all_i,
    input  logic [14:0]       next_y_all_i,
    input  logic [TILE_W-1:0] ram_rdata_i,
    output logic [10:0]       ram_addr_o,
    output logic [TILE_W-1:0] ram_wdata_o,
    output logic              ram_we_o,
    output logic [2:0]        grant_o,
    output logic [2:0]        done_o,
    output logic              busy_o,
    output logic [15:0]       pills_eaten_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RDW   = 3'd2,
        S_ERASE = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Requester indices
    localparam logic [1:0] IDX_PAC = 2'd0;
    localparam logic [1:0] IDX_G1  = 2'd1;
    localparam logic [1:0] IDX_G2  = 2'd2;

    state_t            state_q, state_d;

    logic [1:0]        rr_q;          // round-robin search start
    logic [1:0]        win_q;         // requester being / last served
    logic [2:0]        grant_q;
    logic              mask_q;        // high for the first IDLE cycle after DONE

    logic [5:0]        cx_q, nx_q;    // latched coordinates of the winner
    logic [4:0]        cy_q, ny_q;

    logic [TILE_W-1:0] g1_saved_q;    // tile each ghost is standing on
    logic [TILE_W-1:0] g2_saved_q;
    logic [TILE_W-1:0] saved_new_q;   // tile under the ghost's destination

    logic [2:0]        w_elig;
    logic              w_found;
    logic [1:0]        w_win;
    logic [2:0]        w_sum;
    logic [1:0]        w_cand;
    logic              w_same;

    assign w_same = (cx_q == nx_q) && (cy_q == ny_q);

    //------------------------------------------------------------------------
    // Round-robin arbitration. The previous winner is removed from the
    // eligible set for one IDLE cycle so it cannot be re-granted on the very
    // cycle after its done pulse, giving the location controller time to
    // drop or update its request.
    //------------------------------------------------------------------------
    always_comb begin
        w_elig  = req_i;
        w_found = 1'b0;
        w_win   = rr_q;
        w_sum   = 3'd0;
        w_cand  = 2'd0;
        if (mask_q) begin
            case (win_q)
                IDX_PAC: w_elig[0] = 1'b0;
                IDX_G1:  w_elig[1] = 1'b0;
                IDX_G2:  w_elig[2] = 1'b0;
                default: w_elig    = req_i;
            endcase
        end
        // Walk the search order backwards so the candidate closest to the
        // pointer is the last one assigned and therefore wins.
        for (int k = 2; k >= 0; k--) begin
            w_sum = {1'b0, rr_q} + 3'(k);
            if (w_sum >= 3'd3) begin
                w_sum = w_sum - 3'd3;
            end
            w_cand = w_sum[1:0];
            if (w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    //------------------------------------------------------------------------
    // FSM state register
    //------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------------
    // FSM next state and outputs
    //------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ram_we_o    = 1'b0;
        ram_addr_o  = 11'd0;
        ram_wdata_o = EMPTY_CODE;
        done_o      = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                ram_addr_o = {ny_q, nx_q};
                state_d    = S_RDW;
            end
            S_RDW: begin
                ram_addr_o = {ny_q, nx_q};
                // A move onto its own cell has nothing to erase.
                state_d    = w_same ? S_WRITE : S_ERASE;
            end
            S_ERASE: begin
                ram_we_o   = 1'b1;
                ram_addr_o = {cy_q, cx_q};
                case (win_q)
                    IDX_G1:  ram_wdata_o = g1_saved_q;
                    IDX_G2:  ram_wdata_o = g2_saved_q;
                    default: ram_wdata_o = EMPTY_CODE;
                endcase
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                ram_we_o    = 1'b1;
                ram_addr_o  = {ny_q, nx_q};
                ram_wdata_o = (win_q == IDX_PAC) ? PACMAN_CODE : GHOST_CODE;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done_o  = grant_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q != S_IDLE);
    assign grant_o = grant_q;

    //------------------------------------------------------------------------
    // Datapath: grant latch, coordinates, ghost saved tiles
    //------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rr_q        <= IDX_PAC;
            win_q       <= IDX_PAC;
            grant_q     <= 3'b000;
            mask_q      <= 1'b0;
            cx_q        <= 6'd0;
            cy_q        <= 5'd0;
            nx_q        <= 6'd0;
            ny_q        <= 5'd0;
            g1_saved_q  <= EMPTY_CODE;
            g2_saved_q  <= EMPTY_CODE;
            saved_new_q <= EMPTY_CODE;
        end else begin
            mask_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        win_q   <= w_win;
                        grant_q <= 3'b001 << w_win;
                        rr_q    <= (w_win == IDX_G2) ? IDX_PAC : w_win + 2'd1;
                        case (w_win)
                            IDX_G1: begin
                                cx_q <= curr_x_all_i[11:6];
                                cy_q <= curr_y_all_i[9:5];
                                nx_q <= next_x_all_i[11:6];
                                ny_q <= next_y_all_i[9:5];
                            end
                            IDX_G2: begin
                                cx_q <= curr_x_all_i[17:12];
                                cy_q <= curr_y_all_i[14:10];
                                nx_q <= next_x_all_i[17:12];
                                ny_q <= next_y_all_i[14:10];
                            end
                            default: begin
                                cx_q <= curr_x_all_i[5:0];
                                cy_q <= curr_y_all_i[4:0];
                                nx_q <= next_x_all_i[5:0];
                                ny_q <= next_y_all_i[4:0];
                            end
                        endcase
                    end
                end
                S_RDW: begin
                    // Ghosts only remember pills; anything else under them
                    // is restored as floor when they leave.
                    saved_new_q <= (ram_rdata_i == PILL_CODE) ? PILL_CODE
                                                              : EMPTY_CODE;
                end
                S_WRITE: begin
                    if (!w_same) begin
                        if (win_q == IDX_G1) begin
                            g1_saved_q <= saved_new_q;
                        end
                        if (win_q == IDX_G2) begin
                            g2_saved_q <= saved_new_q;
                        end
                    end
                end
                S_DONE: begin
                    grant_q <= 3'b000;
                end
                default: begin
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Optional pill counter
    //------------------------------------------------------------------------
`ifdef PILL_COUNT_EN
    logic        pill_hit_q;
    logic [15:0] pills_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pill_hit_q <= 1'b0;
            pills_q    <= 16'd0;
        end else begin
            if (state_q == S_RDW) begin
                pill_hit_q <= (win_q == IDX_PAC) && (ram_rdata_i == PILL_CODE);
            end
            if ((state_q == S_WRITE) && pill_hit_q && (pills_q != 16'hFFFF)) begin
                pills_q <= pills_q + 16'd1;
            end
        end
    end

    assign pills_eaten_o = pills_q;
`else
    assign pills_eaten_o = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_map_write_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_map_write_arbiter
// Description : Directed self-checking bench for map_write_arbiter with a
//               behavioural 2048x4 synchronous-read map RAM.
// Revision    : 1.0 - initial release
//============================================================================
module tb_map_write_arbiter;

    localparam logic [3:0] EMPTY = 4'd0;
    localparam logic [3:0] PILL  = 4'd2;
    localparam logic [3:0] PAC   = 4'd3;
    localparam logic [3:0] GHOST = 4'd4;

`ifdef PILL_COUNT_EN
    localparam logic [15:0] PILL_INC = 16'd1;
`else
    localparam logic [15:0] PILL_INC = 16'd0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [2:0]  req      = 3'b000;
    logic [17:0] cxa      = '0;
    logic [17:0] nxa      = '0;
    logic [14:0] cya      = '0;
    logic [14:0] nya      = '0;
    logic [3:0]  rdata;
    logic [10:0] addr;
    logic [3:0]  wdata;
    logic        we;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        busy;
    logic [15:0] pills;

    logic [3:0]  mem [0:2047] = '{default: 4'd0};
    logic        tb_we   = 1'b0;
    logic [10:0] tb_addr = '0;
    logic [3:0]  tb_data = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_done;

    always #10 CLOCK_50 = ~CLOCK_50;

    map_write_arbiter dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .req_i         (req),
        .curr_x_all_i  (cxa),
        .curr_y_all_i  (cya),
        .next_x_all_i  (nxa),
        .next_y_all_i  (nya),
        .ram_rdata_i   (rdata),
        .ram_addr_o    (addr),
        .ram_wdata_o   (wdata),
        .ram_we_o      (we),
        .grant_o       (grant),
        .done_o        (done),
        .busy_o        (busy),
        .pills_eaten_o (pills)
    );

    // Map RAM: bench preload port takes priority over the DUT write port.
    always @(posedge CLOCK_50) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

`define CHK(TAG, OBS, EXP) \
    begin \
        n_tests++; \
        assert ((OBS) === (EXP)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %0h, expected %0h", TAG, (OBS), (EXP)); \
        end \
    end

    task automatic check_eq(input string tag, input logic [15:0] obs,
                            input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic poke(input logic [10:0] a, input logic [3:0] d);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        tick();
        tb_we   = 1'b0;
    endtask

    task automatic set_pos(input int idx, input logic [5:0] cx, input logic [4:0] cy,
                           input logic [5:0] nx, input logic [4:0] ny);
        cxa[6*idx +: 6] = cx;
        cya[5*idx +: 5] = cy;
        nxa[6*idx +: 6] = nx;
        nya[5*idx +: 5] = ny;
    endtask

    initial begin
        //--------------------------------------------------------------
        // Reset values
        //--------------------------------------------------------------
        tick();
        tick();
        check_eq("rst_busy",  {15'd0, busy},  16'h0000);
        check_eq("rst_we",    {15'd0, we},    16'h0000);
        check_eq("rst_addr",  {5'd0, addr},   16'h0000);
        check_eq("rst_wdata", {12'd0, wdata}, 16'h0000);
        check_eq("rst_grant", {13'd0, grant}, 16'h0000);
        check_eq("rst_done",  {13'd0, done},  16'h0000);
        check_eq("rst_pills", pills,          16'h0000);

        //--------------------------------------------------------------
        // Pacman (20,20) -> (20,19) onto a pill.
        // {y,x}: curr = {20,20} = 0x514, next = {19,20} = 0x4D4
        //--------------------------------------------------------------
        poke(11'h4D4, PILL);
        poke(11'h514, PAC);
        set_pos(0, 6'd20, 5'd20, 6'd20, 5'd19);
        reset = 1'b0;
        req   = 3'b001;                       // cycle 0
        tick();                               // cycle 1 RD
        `CHK("pac_c1_grant", grant, 3'b001)
        `CHK("pac_c1_busy",  busy,  1'b1)
        `CHK("pac_c1_addr",  addr,  11'h4D4)
        `CHK("pac_c1_we",    we,    1'b0)
        tick();
        tick();                               // cycle 3 ERASE
        `CHK("pac_c3_we",    we,    1'b1)
        `CHK("pac_c3_addr",  addr,  11'h514)
        `CHK("pac_c3_wdata", wdata, EMPTY)
        tick();                               // cycle 4 WRITE
        `CHK("pac_c4_we",    we,    1'b1)
        `CHK("pac_c4_addr",  addr,  11'h4D4)
        `CHK("pac_c4_wdata", wdata, PAC)
        `CHK("pac_c4_done",  done,  3'b000)
        tick();                               // cycle 5 DONE
        `CHK("pac_c5_done",  done,  3'b001)
        `CHK("pac_c5_pills", pills, PILL_INC)
        `CHK("pac_mem_new",  mem[11'h4D4], PAC)
        `CHK("pac_mem_old",  mem[11'h514], EMPTY)

        //--------------------------------------------------------------
        // Only pacman, req held through done: re-grant in second IDLE.
        // New move {19,20}=0x4D4 -> {19,21}=0x4D5
        //--------------------------------------------------------------
        set_pos(0, 6'd20, 5'd19, 6'd21, 5'd19);
        tick();                               // cycle 6 first IDLE (masked)
        check_eq("solo_c6_done",  {13'd0, done},  16'h0000);
        check_eq("solo_c6_busy",  {15'd0, busy},  16'h0000);
        check_eq("solo_c6_grant", {13'd0, grant}, 16'h0000);
        tick();                               // cycle 7 second IDLE
        check_eq("solo_c7_busy",  {15'd0, busy},  16'h0000);
        tick();                               // cycle 8 RD
        check_eq("solo_c8_busy",  {15'd0, busy},  16'h0001);
        check_eq("solo_c8_grant", {13'd0, grant}, 16'h0001);
        `CHK("solo_c8_addr",  addr,  11'h4D5)
        tick(); tick(); tick(); tick();       // cycle 12 DONE
        `CHK("solo_c12_done", done,  3'b001)
        `CHK("solo_pills",    pills, PILL_INC)
        req = 3'b000;

        //--------------------------------------------------------------
        // All three requesting from reset: pac, g1, g2, pac; 6 apart.
        //--------------------------------------------------------------
        reset = 1'b1;
        req   = 3'b111;
        set_pos(0, 6'd1, 5'd1, 6'd2, 5'd1);
        set_pos(1, 6'd1, 5'd2, 6'd2, 5'd2);
        set_pos(2, 6'd1, 5'd3, 6'd2, 5'd3);
        tick();
        reset = 1'b0;                         // cycle 0
        for (int c = 1; c <= 23; c++) begin
            tick();
            case (c)
                5:       exp_done = 3'b001;
                11:      exp_done = 3'b010;
                17:      exp_done = 3'b100;
                23:      exp_done = 3'b001;
                default: exp_done = 3'b000;
            endcase
            `CHK("rr_done", done, exp_done)
        end
        `CHK("rr_g1_sprite", mem[11'h082], GHOST)
        req   = 3'b000;
        reset = 1'b1;

        //--------------------------------------------------------------
        // Ghost1 (5,5) -> (6,5) onto a pill, then (6,5) -> (7,5):
        // second ERASE restores the pill at 0x146.
        //--------------------------------------------------------------
        poke(11'h145, GHOST);
        poke(11'h146, PILL);
        poke(11'h147, PILL);
        set_pos(1, 6'd5, 5'd5, 6'd6, 5'd5);
        reset = 1'b0;
        req   = 3'b010;                       // cycle 0
        tick();                               // cycle 1
        `CHK("g1_c1_grant", grant, 3'b010)
        tick(); tick();                       // cycle 3 ERASE
        `CHK("g1_c3_addr",  addr,  11'h145)
        `CHK("g1_c3_wdata", wdata, EMPTY)
        tick();                               // cycle 4 WRITE
        `CHK("g1_c4_addr",  addr,  11'h146)
        `CHK("g1_c4_wdata", wdata, GHOST)
        tick();                               // cycle 5 DONE
        `CHK("g1_c5_done",  done,  3'b010)
        req = 3'b000;
        set_pos(1, 6'd6, 5'd5, 6'd7, 5'd5);
        tick();                               // cycle 6 IDLE (masked)
        req = 3'b010;
        tick();                               // cycle 7 IDLE
        `CHK("g1_c7_busy",  busy,  1'b0)
        tick();                               // cycle 8 RD
        `CHK("g1_c8_grant", grant, 3'b010)
        tick(); tick();                       // cycle 10 ERASE
        `CHK("g1_c10_we",    we,    1'b1)
        `CHK("g1_c10_addr",  addr,  11'h146)
        `CHK("g1_c10_wdata", wdata, PILL)
        tick();                               // cycle 11 WRITE
        `CHK("g1_c11_addr",  addr,  11'h147)
        `CHK("g1_c11_wdata", wdata, GHOST)
        tick();                               // cycle 12 DONE
        `CHK("g1_c12_done",  done,  3'b010)
        `CHK("g1_pill_back", mem[11'h146], PILL)
        req = 3'b000;
        tick(); tick();                       // let the mask expire

        //--------------------------------------------------------------
        // Reset during ERASE: pac (1,1)->(2,1), curr addr {1,1}=0x041.
        // Ghost1 is currently saving a pill; reset must clear it.
        //--------------------------------------------------------------
        set_pos(0, 6'd1, 5'd1, 6'd2, 5'd1);
        req = 3'b001;                         // cycle 0
        tick(); tick(); tick();               // cycle 3 ERASE
        `CHK("rst_mid_we_pre",  we,   1'b1)
        `CHK("rst_mid_addr",    addr, 11'h041)
        reset = 1'b1;
        tick();
        `CHK("rst_mid_we",    we,    1'b0)
        `CHK("rst_mid_busy",  busy,  1'b0)
        `CHK("rst_mid_grant", grant, 3'b000)
        `CHK("rst_mid_done",  done,  3'b000)
        reset = 1'b0;
        req   = 3'b111;                       // IDLE: pointer must be pacman
        tick();
        `CHK("rst_mid_rr", grant, 3'b001)
        reset = 1'b1;
        req   = 3'b000;
        tick();
        reset = 1'b0;
        set_pos(1, 6'd7, 5'd5, 6'd8, 5'd5);
        req = 3'b010;                         // cycle 0
        tick(); tick(); tick();               // cycle 3 ERASE
        `CHK("rst_mid_g1_addr",  addr,  11'h147)
        `CHK("rst_mid_g1_saved", wdata, EMPTY)
        reset = 1'b1;
        req   = 3'b000;
        tick();

        //--------------------------------------------------------------
        // Ghost2 with curr==next=(10,3) on a pill: addr {3,10}=0x0CA,
        // no ERASE, done in cycle 4, saved tile left unchanged.
        //--------------------------------------------------------------
        poke(11'h0CA, PILL);
        set_pos(2, 6'd10, 5'd3, 6'd10, 5'd3);
        reset = 1'b0;
        req   = 3'b100;                       // cycle 0
        tick();                               // cycle 1 RD
        `CHK("g2_c1_grant", grant, 3'b100)
        `CHK("g2_c1_addr",  addr,  11'h0CA)
        `CHK("g2_c1_we",    we,    1'b0)
        tick();                               // cycle 2 RDW
        `CHK("g2_c2_we",    we,    1'b0)
        tick();                               // cycle 3 WRITE
        `CHK("g2_c3_we",    we,    1'b1)
        `CHK("g2_c3_addr",  addr,  11'h0CA)
        `CHK("g2_c3_wdata", wdata, GHOST)
        tick();                               // cycle 4 DONE
        `CHK("g2_c4_done",  done,  3'b100)
        req = 3'b000;
        set_pos(2, 6'd10, 5'd3, 6'd11, 5'd3);
        tick(); tick();                       // masked IDLE, then free IDLE
        req = 3'b100;                         // cycle 0
        tick(); tick(); tick();               // cycle 3 ERASE
        `CHK("g2_mv_we",     we,    1'b1)
        `CHK("g2_mv_addr",   addr,  11'h0CA)
        `CHK("g2_mv_saved",  wdata, EMPTY)
        tick();                               // cycle 4 WRITE
        `CHK("g2_mv_waddr",  addr,  11'h0CB)
        `CHK("g2_mv_wdata",  wdata, GHOST)
        tick();                               // cycle 5 DONE
        `CHK("g2_mv_done",   done,  3'b100)
        req = 3'b000;
        tick();
        `CHK("end_busy",     busy,  1'b0)

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail != 0) begin
            $error("FAIL summary: %0d of %0d checks failed", n_fail, n_tests);
        end
        $finish;
    end

`undef CHK

endmodule
`default_nettype wire
